in_buf: RTL and testbench
=========================

// Module: in_buf
// PURPOSE
// - Synchronous FIFO input buffer feeding one row/column of the systolic array.
// - Preloads PADDING zero entries at reset, so the first PADDING reads return 0.
// - This skews each lane's data stream by PADDING cycles relative to other lanes.
// - Several instances with PADDING = 0,1,2,... form the diagonal input wavefront.
// PARAMETERS
// - WIDTH    8   data width in bits
// - DEPTH    16  storage entries; must be a power of 2 and >= 2
// - PADDING  0   zero entries present after reset; 0 <= PADDING <= DEPTH
//                (elaboration-time $error if outside this range)
// PORTS
// - clk    in   1      single clock; all logic on the rising edge
// - rstn   in   1      reset, synchronous and active-high (rstn==1 resets)
// - read   in   1      pop request
// - write  in   1      push request
// - din    in   WIDTH  push data
// - empty  out  1      1 when occupancy == 0
// - full   out  1      1 when occupancy == DEPTH
// - dout   out  WIDTH  registered pop data
// BEHAVIOUR
// - Reset (rstn==1 at a clk edge):
//   - wptr = PADDING mod DEPTH, rptr = 0, count = PADDING.
//   - mem[0..PADDING-1] = 0 and dout = 0.
//   - empty = (PADDING==0), full = (PADDING==DEPTH).
//   - Reset dominates read/write in the same cycle.
//   - Mid-operation reset discards all contents and re-preloads the padding.
// - Push accepted = write && (!full || read).
//   - On accept: mem[wptr] <= din, and wptr increments, wrapping modulo DEPTH.
// - Pop accepted = read && !empty.
//   - On accept: dout <= mem[rptr] one cycle after the request edge, and rptr wraps.
// - Read while empty: dout <= 0 (zero bubble) and no pointer change.
//   - No write-to-read bypass: an empty buffer with read && write pops 0 and
//     stores din.
// - No read: dout holds its previous value.
// - count update: +1 push only; -1 pop only; unchanged when both or neither.
// - Write while full without read: din dropped, no state change, no error flag.
// - Full with read && write: both accepted and count stays DEPTH.
// - empty and full are combinational decodes of the registered count, so they
//   reflect the state after the last edge.
// - count is $clog2(DEPTH)+1 bits wide; there is no other arithmetic.
// STRUCTURE
// - Shared package systola_pkg: DATA_W = 8 default and typedef logic [DATA_W-1:0] data_t.
// - One sub-module, in_buf_mem: a DEPTH x WIDTH simple dual-port register array
//   with a synchronous write port and an asynchronous read port.
// - Pointers, count, padding preload, flags and the dout register live in in_buf.
// - in_buf_mem needs a reset or preload hook so in_buf can zero the entries.
// TESTING
// - Reset: PADDING=3, hold rstn=1 for 2 cycles.
//   -> empty=0, full=0, dout=0, count=3.
// - Padding skew: PADDING=3, write+read 5 cycles with din 1..5.
//   -> dout 0,0,0,1,2; count stays 3.
// - Write then drain: continue write-only with din 6,7,8, then read-only for 6 cycles.
//   -> dout 3,4,5,6,7,8; empty=1 after the 6th pop.
// - Empty simultaneous read/write: PADDING=0, write+read with din 1..5.
//   -> dout 0,1,2,3,4 (no bypass); ends with count=1.
// - Read underflow: PADDING=7, read 9 cycles with no writes.
//   -> dout 0 throughout; empty asserts after the 7th pop; pointers hold afterwards.
// - Full and wrap: PADDING=0, write 17 values 1..17.
//   -> full=1 after 16 writes and value 17 dropped.
//   -> then read+write with din 20 -> dout 1, full stays 1.
//   -> draining yields 2..16 then 20, checking pointer wrap.

Source files
------------

// File: rtl/systola_pkg.sv
// Shared types and defaults for the systolic array datapath.
package systola_pkg;

  localparam int unsigned DATA_W = 8;

  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/in_buf_mem.sv
// DEPTH x WIDTH register array: synchronous write port, asynchronous read port,
// and a synchronous clear that zeroes the first PADDING entries.
module in_buf_mem
  import systola_pkg::*;
#(
  parameter int unsigned WIDTH   = DATA_W,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned PADDING = 0,
  parameter int unsigned AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (clr) begin
      // Only the padding entries are zeroed; the rest are unreachable until written.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (i < PADDING) mem_d[i] = '0;
      end
    end else if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/in_buf.sv
// Input FIFO for one systolic lane; PADDING zero entries preloaded at reset
// skew this lane's stream relative to its neighbours.
module in_buf
  import systola_pkg::*;
#(
  parameter int unsigned WIDTH   = DATA_W,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned PADDING = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             read,
  input  logic             write,
  input  logic [WIDTH-1:0] din,
  output logic             empty,
  output logic             full,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [AW-1:0] WPTR_RST  = AW'(PADDING % DEPTH);
  localparam logic [CW-1:0] COUNT_RST = CW'(PADDING);
  localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

  if (PADDING > DEPTH) begin : g_bad_padding
    $error("in_buf: PADDING (%0d) must not exceed DEPTH (%0d)", PADDING, DEPTH);
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("in_buf: DEPTH (%0d) must be a power of 2 and >= 2", DEPTH);
  end

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] rdata;
  logic             push, pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == COUNT_MAX);

  // A read frees a slot in the same edge, so a full buffer still accepts a write alongside it.
  assign push = write && (!full || read) && !rstn;
  assign pop  = read && !empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    dout_d  = dout_q;
    if (rstn) begin
      wptr_d  = WPTR_RST;
      rptr_d  = '0;
      count_d = COUNT_RST;
      dout_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      if (read) dout_d = pop ? rdata : '0;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    wptr_q  <= wptr_d;
    rptr_q  <= rptr_d;
    count_q <= count_d;
    dout_q  <= dout_d;
  end

  assign dout = dout_q;

  in_buf_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .PADDING(PADDING)
  ) u_mem (
    .clk  (clk),
    .clr  (rstn),
    .we   (push),
    .waddr(wptr_q),
    .wdata(din),
    .raddr(rptr_q),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_in_buf.sv
// Directed bench for in_buf with three instances (PADDING = 3, 0, 7) sharing inputs.
module tb_in_buf;

  logic       clk = 1'b0;
  logic       rst, rd, wr;
  logic [7:0] din;
  logic       e3, f3, e0, f0, e7, f7;
  logic [7:0] d3, d0, d7;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  in_buf #(.WIDTH(8), .DEPTH(16), .PADDING(3)) u_p3 (
    .clk(clk), .rstn(rst), .read(rd), .write(wr), .din(din),
    .empty(e3), .full(f3), .dout(d3)
  );
  in_buf #(.WIDTH(8), .DEPTH(16), .PADDING(0)) u_p0 (
    .clk(clk), .rstn(rst), .read(rd), .write(wr), .din(din),
    .empty(e0), .full(f0), .dout(d0)
  );
  in_buf #(.WIDTH(8), .DEPTH(16), .PADDING(7)) u_p7 (
    .clk(clk), .rstn(rst), .read(rd), .write(wr), .din(din),
    .empty(e7), .full(f7), .dout(d7)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rd = 1'b0; wr = 1'b0; din = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (e3 !== 1'b0) begin n_bad++; $display("FAIL reset_empty3 got=%b exp=0", e3); end
    n_cmp++; if (f3 !== 1'b0) begin n_bad++; $display("FAIL reset_full3 got=%b exp=0", f3); end
    n_cmp++; if (d3 !== 8'd0) begin n_bad++; $display("FAIL reset_dout3 got=%0d exp=0", d3); end
    n_cmp++; if (u_p3.count_q !== 5'd3) begin n_bad++; $display("FAIL reset_count3 got=%0d exp=3", u_p3.count_q); end
    n_cmp++; if (e0 !== 1'b1) begin n_bad++; $display("FAIL reset_empty0 got=%b exp=1", e0); end
    n_cmp++; if (e7 !== 1'b0) begin n_bad++; $display("FAIL reset_empty7 got=%b exp=0", e7); end
    // reset must dominate a simultaneous read/write
    rst = 1'b1; rd = 1'b1; wr = 1'b1; din = 8'hAA;
    tick();
    rst = 1'b0; rd = 1'b0; wr = 1'b0;
    n_cmp++; if (u_p3.count_q !== 5'd3) begin n_bad++; $display("FAIL reset_dom_count got=%0d exp=3", u_p3.count_q); end
    n_cmp++; if (u_p3.wptr_q !== 4'd3) begin n_bad++; $display("FAIL reset_dom_wptr got=%0d exp=3", u_p3.wptr_q); end
    n_cmp++; if (d3 !== 8'd0) begin n_bad++; $display("FAIL reset_dom_dout got=%0d exp=0", d3); end
  endtask

  task automatic test_padding_skew();
    logic [7:0] exp [5] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd2};
    for (int i = 0; i < 5; i++) begin
      rd = 1'b1; wr = 1'b1; din = 8'(i + 1);
      tick();
      n_cmp++; if (d3 !== exp[i]) begin n_bad++; $display("FAIL skew_dout[%0d] got=%0d exp=%0d", i, d3, exp[i]); end
    end
    rd = 1'b0; wr = 1'b0;
    n_cmp++; if (u_p3.count_q !== 5'd3) begin n_bad++; $display("FAIL skew_count got=%0d exp=3", u_p3.count_q); end
  endtask

  task automatic test_write_drain();
    for (int i = 0; i < 3; i++) begin
      rd = 1'b0; wr = 1'b1; din = 8'(6 + i);
      tick();
    end
    wr = 1'b0;
    n_cmp++; if (u_p3.count_q !== 5'd6) begin n_bad++; $display("FAIL drain_count got=%0d exp=6", u_p3.count_q); end
    n_cmp++; if (d3 !== 8'd2) begin n_bad++; $display("FAIL drain_hold got=%0d exp=2", d3); end
    for (int i = 0; i < 6; i++) begin
      rd = 1'b1;
      tick();
      n_cmp++; if (d3 !== 8'(3 + i)) begin n_bad++; $display("FAIL drain_dout[%0d] got=%0d exp=%0d", i, d3, 3 + i); end
      n_cmp++; if (e3 !== (i == 5)) begin n_bad++; $display("FAIL drain_empty[%0d] got=%b exp=%b", i, e3, (i == 5)); end
    end
    rd = 1'b0;
  endtask

  task automatic test_empty_rw();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      rd = 1'b1; wr = 1'b1; din = 8'(i + 1);
      tick();
      n_cmp++; if (d0 !== 8'(i)) begin n_bad++; $display("FAIL emptyrw_dout[%0d] got=%0d exp=%0d", i, d0, i); end
    end
    rd = 1'b0; wr = 1'b0;
    n_cmp++; if (u_p0.count_q !== 5'd1) begin n_bad++; $display("FAIL emptyrw_count got=%0d exp=1", u_p0.count_q); end
  endtask

  task automatic test_underflow();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      rd = 1'b1; wr = 1'b0;
      tick();
      n_cmp++; if (d7 !== 8'd0) begin n_bad++; $display("FAIL under_dout[%0d] got=%0d exp=0", i, d7); end
      n_cmp++; if (e7 !== (i >= 6)) begin n_bad++; $display("FAIL under_empty[%0d] got=%b exp=%b", i, e7, (i >= 6)); end
    end
    rd = 1'b0;
    n_cmp++; if (u_p7.rptr_q !== 4'd7) begin n_bad++; $display("FAIL under_rptr got=%0d exp=7", u_p7.rptr_q); end
    n_cmp++; if (u_p7.count_q !== 5'd0) begin n_bad++; $display("FAIL under_count got=%0d exp=0", u_p7.count_q); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      rd = 1'b0; wr = 1'b1; din = 8'(i + 1);
      tick();
      n_cmp++; if (f0 !== (i >= 15)) begin n_bad++; $display("FAIL full_flag[%0d] got=%b exp=%b", i, f0, (i >= 15)); end
    end
    n_cmp++; if (u_p0.count_q !== 5'd16) begin n_bad++; $display("FAIL full_count got=%0d exp=16", u_p0.count_q); end
    n_cmp++; if (u_p0.wptr_q !== 4'd0) begin n_bad++; $display("FAIL full_wptr got=%0d exp=0", u_p0.wptr_q); end
    rd = 1'b1; wr = 1'b1; din = 8'd20;
    tick();
    n_cmp++; if (d0 !== 8'd1) begin n_bad++; $display("FAIL full_rw_dout got=%0d exp=1", d0); end
    n_cmp++; if (f0 !== 1'b1) begin n_bad++; $display("FAIL full_rw_full got=%b exp=1", f0); end
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp;
      exp = (i < 15) ? 8'(i + 2) : 8'd20;
      rd = 1'b1; wr = 1'b0;
      tick();
      n_cmp++; if (d0 !== exp) begin n_bad++; $display("FAIL wrap_dout[%0d] got=%0d exp=%0d", i, d0, exp); end
    end
    rd = 1'b0;
    n_cmp++; if (e0 !== 1'b1) begin n_bad++; $display("FAIL wrap_empty got=%b exp=1", e0); end
    n_cmp++; if (u_p0.rptr_q !== 4'd1) begin n_bad++; $display("FAIL wrap_rptr got=%0d exp=1", u_p0.rptr_q); end
  endtask

  initial begin
    rst = 1'b0; rd = 1'b0; wr = 1'b0; din = '0;
    test_reset();
    test_padding_skew();
    test_write_drain();
    test_empty_rw();
    test_underflow();
    test_full_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
